shift_rotate_unit_8bit: RTL and testbench

//   Registered 8-bit shift/rotate unit for the barrel-shifter datapath.
//   - Performs arithmetic left shift, arithmetic right shift or left rotate of an 8-bit operand.
//   - Shift amount is 0..7, selected by an op code.
//   - Result is registered with a 1-cycle valid pipeline.

---
 rtl/shift_rotate_pkg.sv | 15 +
 rtl/shift_rotate_unit_8bit_mux8to1.sv | 12 +
 rtl/shift_rotate_unit_8bit.sv | 91 +++++++++
 tb/tb_shift_rotate_unit_8bit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/shift_rotate_pkg.sv
// Shared types and sizes for the registered 8-bit shift/rotate unit.
// Optional feature macro used by the unit: SHIFT_ROR_EN (op=11 becomes rotate right).
package shift_rotate_pkg;

    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;

    typedef enum logic [1:0] {
        OP_ASL      = 2'b00,
        OP_ASR      = 2'b01,
        OP_ROL      = 2'b10,
        OP_ROR_PASS = 2'b11
    } op_e;

endpackage

// File: rtl/shift_rotate_unit_8bit_mux8to1.sv
// 8-input, 1-bit selector; one instance picks one result bit for one op by amount.
module mux8to1
    import shift_rotate_pkg::*;
(
    input  logic [(2**AMT_W)-1:0] d,
    input  logic [AMT_W-1:0]      sel,
    output logic                  y
);

    assign y = d[sel];

endmodule

// File: rtl/shift_rotate_unit_8bit.sv
// Registered 8-bit shift/rotate unit: ASL, ASR, ROL and op=11 as rotate right
// when SHIFT_ROR_EN is defined, otherwise pass-through. One-cycle latency.
module shift_rotate_unit_8bit
    import shift_rotate_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [1:0]        op,
    input  logic [AMT_W-1:0]  S,
    input  logic [DATA_W-1:0] inp,
    output logic [DATA_W-1:0] out,
    output logic              out_valid
);

    localparam int NSEL = 2**AMT_W;

    // Per output bit i, entry j of each vector is that bit's value for amount j.
    logic [NSEL-1:0]   asl_d [DATA_W];
    logic [NSEL-1:0]   asr_d [DATA_W];
    logic [NSEL-1:0]   rol_d [DATA_W];
    logic [DATA_W-1:0] asl_r;
    logic [DATA_W-1:0] asr_r;
    logic [DATA_W-1:0] rol_r;
    logic [DATA_W-1:0] op3_r;
    logic [DATA_W-1:0] result;

`ifdef SHIFT_ROR_EN
    logic [NSEL-1:0]   ror_d [DATA_W];
`endif

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        for (genvar j = 0; j < NSEL; j++) begin : g_amt
            // Fill and wrap constants are resolved at elaboration, so each
            // mux input is either an operand bit or a fixed zero.
            if (j <= i) begin : g_asl_src
                assign asl_d[i][j] = inp[i-j];
            end else begin : g_asl_zero
                assign asl_d[i][j] = 1'b0;
            end

            if (i + j <= DATA_W - 1) begin : g_asr_src
                assign asr_d[i][j] = inp[i+j];
            end else begin : g_asr_sign
                assign asr_d[i][j] = inp[DATA_W-1];
            end

            assign rol_d[i][j] = inp[(i - j + DATA_W) % DATA_W];
`ifdef SHIFT_ROR_EN
            assign ror_d[i][j] = inp[(i + j) % DATA_W];
`endif
        end

        mux8to1 u_asl (.d(asl_d[i]), .sel(S), .y(asl_r[i]));
        mux8to1 u_asr (.d(asr_d[i]), .sel(S), .y(asr_r[i]));
        mux8to1 u_rol (.d(rol_d[i]), .sel(S), .y(rol_r[i]));
`ifdef SHIFT_ROR_EN
        mux8to1 u_ror (.d(ror_d[i]), .sel(S), .y(op3_r[i]));
`else
        assign op3_r[i] = inp[i];
`endif
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // result unassigned, which would otherwise infer a latch.
        result = inp;
        case (op_e'(op))
            OP_ASL:      result = asl_r;
            OP_ASR:      result = asr_r;
            OP_ROL:      result = rol_r;
            OP_ROR_PASS: result = op3_r;
            default:     result = inp;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= result;
            end
        end
    end

endmodule

// File: tb/tb_shift_rotate_unit_8bit.sv
// Self-checking bench for shift_rotate_unit_8bit: vector table, random stream
// with a scoreboard queue, and reset/hold sequences.
module tb_shift_rotate_unit_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] op;
    logic [2:0] S;
    logic [7:0] inp;
    logic [7:0] out;
    logic       out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb_q [$];
    logic [7:0] held;

    typedef struct {
        logic [1:0] op;
        logic [2:0] s;
        logic [7:0] inp;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [16];

    shift_rotate_unit_8bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .op        (op),
        .S         (S),
        .inp       (inp),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_calc(input logic [1:0] o, input logic [2:0] s,
                                            input logic [7:0] d);
        logic [15:0] t;
        logic [7:0]  r;
        case (o)
            2'b00: r = d << s;
            2'b01: r = $unsigned($signed(d) >>> s);
            2'b10: begin t = {d, d} << s; r = t[15:8]; end
            default: begin
`ifdef SHIFT_ROR_EN
                t = {d, d} >> s; r = t[7:0];
`else
                r = d;
`endif
            end
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle; the result of this cycle's stimulus is checked #1 after the edge.
    task automatic cycle(input string name, input logic r, input logic v,
                         input logic [1:0] o, input logic [2:0] s,
                         input logic [7:0] d, input logic [7:0] exp);
        logic [7:0] e;
        rst = r; in_valid = v; op = o; S = s; inp = d;
        if (!r && v) sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (r) begin
            sb_q.delete();
            held = 8'h00;
            check({name, " rst out"}, out, 8'h00);
            check({name, " rst valid"}, {7'b0, out_valid}, 8'h00);
        end else if (v) begin
            if (sb_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL %s: scoreboard empty", name);
            end else begin
                e = sb_q.pop_front();
                held = e;
                check({name, " out"}, out, e);
                check({name, " valid"}, {7'b0, out_valid}, 8'h01);
            end
        end else begin
            check({name, " hold out"}, out, held);
            check({name, " idle valid"}, {7'b0, out_valid}, 8'h00);
        end
    endtask

    initial begin
        vecs[0]  = '{2'b00, 3'd3, 8'b11001100, 8'b01100000};
        vecs[1]  = '{2'b01, 3'd6, 8'b11101101, 8'b11111111};
        vecs[2]  = '{2'b01, 3'd2, 8'b00001100, 8'b00000011};
        vecs[3]  = '{2'b10, 3'd1, 8'b11001100, 8'b10011001};
        vecs[4]  = '{2'b10, 3'd0, 8'b11001100, 8'b11001100};
`ifdef SHIFT_ROR_EN
        vecs[5]  = '{2'b11, 3'd4, 8'b11101101, 8'b11011110};
        vecs[6]  = '{2'b11, 3'd1, 8'h01, 8'h80};
`else
        vecs[5]  = '{2'b11, 3'd4, 8'b11101101, 8'b11101101};
        vecs[6]  = '{2'b11, 3'd1, 8'h01, 8'h01};
`endif
        vecs[7]  = '{2'b01, 3'd7, 8'h7F, 8'h00};
        vecs[8]  = '{2'b01, 3'd7, 8'h80, 8'hFF};
        vecs[9]  = '{2'b00, 3'd7, 8'hFF, 8'h80};
        vecs[10] = '{2'b10, 3'd7, 8'h81, 8'hC0};
        vecs[11] = '{2'b01, 3'd0, 8'hA5, 8'hA5};
        vecs[12] = '{2'b00, 3'd0, 8'h3C, 8'h3C};
        vecs[13] = '{2'b11, 3'd0, 8'h96, 8'h96};
        vecs[14] = '{2'b01, 3'd3, 8'h90, 8'hF2};
        vecs[15] = '{2'b00, 3'd1, 8'h81, 8'h02};

        held = 8'h00;

        // Reset held for two cycles while in_valid is high.
        cycle("reset0", 1'b1, 1'b1, 2'b00, 3'd1, 8'hFF, 8'h00);
        cycle("reset1", 1'b1, 1'b1, 2'b00, 3'd1, 8'hFF, 8'h00);

        // Table vectors, back-to-back.
        for (int i = 0; i < 16; i++) begin
            cycle($sformatf("vec%0d", i), 1'b0, 1'b1, vecs[i].op, vecs[i].s,
                  vecs[i].inp, vecs[i].exp);
        end

        // Random stream with idle gaps, expectations from the reference model.
        for (int i = 0; i < 60; i++) begin
            logic       v;
            logic [1:0] o;
            logic [2:0] s;
            logic [7:0] d;
            v = ($urandom_range(0, 3) != 0);
            o = 2'($urandom_range(0, 3));
            s = 3'($urandom_range(0, 7));
            d = 8'($urandom_range(0, 255));
            cycle($sformatf("rnd%0d", i), 1'b0, v, o, s, d, ref_calc(o, s, d));
        end

        // Reset mid-stream, then idle: output stays cleared.
        cycle("pre_rst_a", 1'b0, 1'b1, 2'b10, 3'd2, 8'h5A, 8'h69);
        cycle("pre_rst_b", 1'b0, 1'b1, 2'b00, 3'd4, 8'h0F, 8'hF0);
        cycle("mid_rst",   1'b1, 1'b1, 2'b00, 3'd1, 8'h33, 8'h00);
        cycle("post_rst",  1'b0, 1'b0, 2'b00, 3'd1, 8'h33, 8'h00);

        // Idle after a result: out holds, out_valid drops.
        cycle("load",  1'b0, 1'b1, 2'b01, 3'd1, 8'h84, 8'hC2);
        cycle("idle1", 1'b0, 1'b0, 2'b10, 3'd5, 8'hFF, 8'h00);
        cycle("idle2", 1'b0, 1'b0, 2'b01, 3'd3, 8'h11, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
